// File: rtl/fpadd_pkg.sv
// Shared format constants and pipeline register layouts for the FP add datapath.
// The FP format is selected here; fpadd_pipe parameters must agree with it.
package fpadd_pkg;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int BIAS     = 2**(FP_EXP_W-1)-1;
   localparam int EXP_MAX  = 2**FP_EXP_W-1;
   localparam int FRAC_W   = FP_MAN_W+4;
   // signed working exponent: room for +carry and -(FRAC_W+1) normalise
   localparam int EXPI_W   = FP_EXP_W+2;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FRAC_W-1:0]   frac;
   } fp_unpacked_t;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic                sub;
      logic [FRAC_W-1:0]   frac_l;
      logic [FRAC_W-1:0]   frac_s;
   } s1_reg_t;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FRAC_W:0]     sum;
   } s2_reg_t;
endpackage

// File: rtl/fpadd_pipe_lzc.sv
// Parametrised leading-zero counter; returns WIDTH for an all-zero input.
module fp_lzc #(
   parameter int WIDTH = 28,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CNT_W-1:0] count
);
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CNT_W'(WIDTH-1-i);
      end
   end
endmodule

// File: rtl/fpadd_pipe.sv
// 3-stage pipelined FP adder/subtractor (align, add, normalise/round RNE) with
// valid/ready handshake; a downstream stall freezes every stage.
module fpadd_pipe
   import fpadd_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op_sub,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   ovf,
   output logic                   unf
);
   localparam int LZ_W = $clog2(FRAC_W+2);
   localparam logic [EXP_W-1:0] FAR_SHIFT = EXP_W'(MAN_W+3);

   if (EXP_W != FP_EXP_W || MAN_W != FP_MAN_W) begin : g_fmt_mismatch
      $error("fpadd_pipe: EXP_W/MAN_W must match fpadd_pkg FP_EXP_W/FP_MAN_W");
   end

   logic en;
   logic v1, v2;

   assign en       = ~(out_valid & ~out_ready);
   assign in_ready = en;

   // S1: unpack, order by magnitude, align smaller operand
   fp_unpacked_t     op_a, op_b, op_l, op_s;
   logic             a_ge_b;
   logic [EXP_W-1:0] exp_diff;
   logic [FRAC_W-1:0] align_mask, frac_aln;
   s1_reg_t          s1_d, s1_q;

   always_comb begin
      op_a.sign = a[EXP_W+MAN_W];
      op_a.exp  = a[EXP_W+MAN_W-1:MAN_W];
      op_a.frac = {1'b1, a[MAN_W-1:0], 3'b000};
      op_b.sign = b[EXP_W+MAN_W] ^ op_sub;
      op_b.exp  = b[EXP_W+MAN_W-1:MAN_W];
      op_b.frac = {1'b1, b[MAN_W-1:0], 3'b000};
      a_ge_b    = a[EXP_W+MAN_W-1:0] >= b[EXP_W+MAN_W-1:0];
      op_l      = a_ge_b ? op_a : op_b;
      op_s      = a_ge_b ? op_b : op_a;
      exp_diff  = op_l.exp - op_s.exp;
      align_mask = ~({FRAC_W{1'b1}} << exp_diff);
      if (exp_diff >= FAR_SHIFT) begin
         frac_aln = {{(FRAC_W-1){1'b0}}, 1'b1};
      end else begin
         frac_aln = (op_s.frac >> exp_diff)
                  | {{(FRAC_W-1){1'b0}}, |(op_s.frac & align_mask)};
      end
      s1_d.sign   = op_l.sign;
      s1_d.exp    = op_l.exp;
      s1_d.sub    = op_l.sign ^ op_s.sign;
      s1_d.frac_l = op_l.frac;
      s1_d.frac_s = frac_aln;
   end

   // S2: magnitude add/subtract; larger operand first so no negative result
   s2_reg_t s2_d, s2_q;

   always_comb begin
      s2_d.sign = s1_q.sign;
      s2_d.exp  = s1_q.exp;
      if (s1_q.sub) s2_d.sum = {1'b0, s1_q.frac_l} - {1'b0, s1_q.frac_s};
      else          s2_d.sum = {1'b0, s1_q.frac_l} + {1'b0, s1_q.frac_s};
   end

   // S3: normalise so the leading one lands on the carry bit, then drop it
   logic [LZ_W-1:0]    lz;
   logic [FRAC_W:0]    shifted;
   logic [FRAC_W-1:0]  norm;
   logic [EXPI_W-1:0]  exp_n, exp_r;
   logic [MAN_W:0]     man_rnd;
   logic               round_up, sum_zero;
   logic [EXP_W+MAN_W:0] res_d;
   logic               ovf_d, unf_d;

   fp_lzc #(.WIDTH(FRAC_W+1), .CNT_W(LZ_W)) u_lzc (
      .value (s2_q.sum),
      .count (lz)
   );

   always_comb begin
      shifted  = s2_q.sum << lz;
      norm     = {shifted[FRAC_W:2], shifted[1] | shifted[0]};
      sum_zero = ~norm[FRAC_W-1];
      exp_n    = {2'b00, s2_q.exp} + EXPI_W'(1) - EXPI_W'(lz);
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      man_rnd  = {1'b0, norm[FRAC_W-2:3]} + (MAN_W+1)'(round_up);
      exp_r    = man_rnd[MAN_W] ? exp_n + EXPI_W'(1) : exp_n;
      res_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (!sum_zero) begin
         if (!exp_r[EXPI_W-1] && exp_r >= EXPI_W'(EXP_MAX)) begin
            res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
         end else if (exp_r[EXPI_W-1] || exp_r == '0) begin
            unf_d = 1'b1;
         end else begin
            res_d = {s2_q.sign, exp_r[EXP_W-1:0], man_rnd[MAN_W-1:0]};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         result    <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         result    <= res_d;
         ovf       <= ovf_d;
         unf       <= unf_d;
      end
   end
endmodule

// File: tb/tb_fpadd_pipe.sv
// Self-checking bench for fpadd_pipe (FP32): exact-arithmetic reference model,
// scoreboard on every output transfer, directed vectors with literal results.
module tb_fpadd_pipe;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, op_sub;
   logic [31:0] a, b, result;
   logic        out_valid, out_ready, ovf, unf;

   int tests = 0;
   int fails = 0;
   int outputs_seen = 0;
   logic [33:0] exp_q[$];
   logic        stall_prev = 1'b0;
   logic [33:0] held;

   always #5 clk = ~clk;

   fpadd_pipe dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .ovf(ovf), .unf(unf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   task automatic bound_fail(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: bound expired, got no event, expected one", nm);
   endtask

   // Exact sum as wide integers, then one RNE rounding to 24 bits.
   function automatic logic [33:0] fp_model(input logic [31:0] x, input logic [31:0] y, input logic sub);
      logic sx, sy, sr, up;
      int ex, ey, elo, p, e, sh;
      logic [289:0] mx, my, mag, rem, half, q;
      sx = x[31];
      sy = y[31] ^ sub;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = {266'd0, 1'b1, x[22:0]};
      my = {266'd0, 1'b1, y[22:0]};
      elo = (ex < ey) ? ex : ey;
      mx = mx << (ex - elo);
      my = my << (ey - elo);
      if (sx == sy)      begin mag = mx + my; sr = sx; end
      else if (mx >= my) begin mag = mx - my; sr = sx; end
      else               begin mag = my - mx; sr = sy; end
      if (mag == '0) return 34'd0;
      p = 0;
      for (int i = 0; i < 290; i++) if (mag[i]) p = i;
      e = p + elo - 23;
      if (p > 23) begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag & ((290'd1 << sh) - 290'd1);
         half = 290'd1 << (sh - 1);
         up   = (rem > half) || (rem == half && q[0]);
         q    = q + 290'(up);
         if (q[24]) begin q = q >> 1; e = e + 1; end
      end else begin
         q = mag << (23 - p);
      end
      if (e >= 255) return {2'b10, sr, 8'hFF, 23'd0};
      if (e <= 0)   return {2'b01, 32'd0};
      return {2'b00, sr, e[7:0], q[22:0]};
   endfunction

   // Scoreboard: sampled mid-cycle, reflecting the transfers of the next edge.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         stall_prev = 1'b0;
         chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
         if (stall_prev) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {30'd0, ovf, unf, result}, {30'd0, held});
         end
         if (in_valid && in_ready) exp_q.push_back(fp_model(a, b, op_sub));
         if (out_valid && out_ready) begin
            outputs_seen++;
            if (exp_q.size() == 0) bound_fail("sb_spurious_output");
            else chk("sb_result", {30'd0, ovf, unf, result}, {30'd0, exp_q.pop_front()});
         end
         stall_prev = out_valid && !out_ready;
         held = {ovf, unf, result};
      end
   end

   task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
      int t = 0;
      logic done = 1'b0;
      in_valid = 1'b1; a = ta; b = tb; op_sub = ts;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         t++;
         if (!done && t > 100) begin bound_fail("issue_wait"); done = 1'b1; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_single(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                             input logic ts, input logic [33:0] req);
      int lat = 0;
      issue(ta, tb, ts);
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
      chk({nm, "_latency"}, 64'(lat), 64'd3);
      chk(nm, {30'd0, ovf, unf, result}, {30'd0, req});
      @(posedge clk); #1;
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while (exp_q.size() != 0 && t < 60) begin @(negedge clk); t++; end
      if (exp_q.size() != 0) bound_fail(nm);
      @(posedge clk); #1;
   endtask

   logic [31:0] va[8] = '{32'h3DCCCCCD, 32'h449A4000, 32'h7F000000, 32'h00FFFFFF,
                          32'h4B800000, 32'hC1A00000, 32'h3F7FFFFF, 32'h40490FDB};
   logic [31:0] vb[8] = '{32'h3E4CCCCD, 32'hC49A4000, 32'h7F000000, 32'h00800000,
                          32'h3F800000, 32'h41200000, 32'h33800000, 32'hBF800000};
   logic        vs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [15:0] bp_pat = 16'hA6C3;

   initial begin
      int base, t;
      in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1; reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_result", {30'd0, ovf, unf, result}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

      chk("model_1p1", {30'd0, fp_model(32'h3F800000, 32'h3F800000, 1'b0)}, {30'd0, 34'h040000000});
      chk("model_cancel", {30'd0, fp_model(32'h3FC00000, 32'h3FC00000, 1'b1)}, 64'd0);
      chk("model_tie_even", {30'd0, fp_model(32'h3F800000, 32'h33800000, 1'b0)}, {30'd0, 34'h03F800000});
      chk("model_tie_odd", {30'd0, fp_model(32'h3F800001, 32'h33800000, 1'b0)}, {30'd0, 34'h03F800002});
      chk("model_ovf", {30'd0, fp_model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0)}, {30'd0, 34'h27F800000});
      chk("model_deep", {30'd0, fp_model(32'h3F800001, 32'h3F800000, 1'b1)}, {30'd0, 34'h034000000});

      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_single("add_1p1",     32'h3F800000, 32'h3F800000, 1'b0, {2'b00, 32'h40000000});
      run_single("sub_zero",    32'h3FC00000, 32'h3FC00000, 1'b1, {2'b00, 32'h00000000});
      run_single("tie_even",    32'h3F800000, 32'h33800000, 1'b0, {2'b00, 32'h3F800000});
      run_single("tie_odd",     32'h3F800001, 32'h33800000, 1'b0, {2'b00, 32'h3F800002});
      run_single("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {2'b10, 32'h7F800000});
      run_single("deep_norm",   32'h3F800001, 32'h3F800000, 1'b1, {2'b00, 32'h34000000});
      run_single("underflow",   32'h00800001, 32'h00800000, 1'b1, {2'b01, 32'h00000000});
      run_single("neg_result",  32'hC0000000, 32'h3F800000, 1'b0, {2'b00, 32'hBF800000});
      run_single("swap_sub",    32'h3F800000, 32'h40000000, 1'b1, {2'b00, 32'hBF800000});
      run_single("far_sticky",  32'h3F800000, 32'h0C000000, 1'b1, {2'b00, 32'h3F800000});

      // back-to-back issue against a 5+ cycle downstream stall
      base = outputs_seen;
      out_ready = 1'b0;
      fork
         begin
            issue(32'h40400000, 32'h40400000, 1'b0);
            issue(32'h41200000, 32'h3F800000, 1'b0);
            issue(32'h42C80000, 32'h41200000, 1'b1);
            issue(32'hBF800000, 32'hBF800000, 1'b0);
         end
         begin
            t = 0;
            do begin @(negedge clk); t++; end while (!out_valid && t < 20);
            if (!out_valid) bound_fail("stall_wait_valid");
            repeat (5) begin
               chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
               @(negedge clk);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("stall_drain");
      chk("stall_count", 64'(outputs_seen - base), 64'd4);

      // streaming with patterned back-pressure
      base = outputs_seen;
      fork
         for (int i = 0; i < 8; i++) issue(va[i], vb[i], vs[i]);
         for (int k = 0; k < 40; k++) begin
            out_ready = bp_pat[k % 16];
            @(posedge clk); #1;
         end
      join
      out_ready = 1'b1;
      drain("bp_drain");
      chk("bp_count", 64'(outputs_seen - base), 64'd8);

      // reset with three operations in flight
      base = outputs_seen;
      out_ready = 1'b0;
      issue(32'h40400000, 32'h3F800000, 1'b0);
      issue(32'h40A00000, 32'h3F800000, 1'b1);
      in_valid = 1'b1; a = 32'h41000000; b = 32'h41000000; op_sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1 reset = 1'b1;
      #1 chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_no_emit", 64'(outputs_seen - base), 64'd0);
      @(posedge clk); #1;
      run_single("post_reset",  32'h40400000, 32'h40400000, 1'b0, {2'b00, 32'h40C00000});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
